rojo_int_ctrl: RTL

ROJO_INT_CTRL -- requirements
Module: rojo_int_ctrl

---
 rtl/rojo_int_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rojo_int_ctrl.sv
// Edge-triggered interrupt controller for a small port-mapped processor.
// Three registers (PENDING, MASK, VECTOR/EOI) and an IDLE/REQ/SERVICE handshake FSM.
module rojo_int_ctrl #(
    parameter int                    NUM_SRC    = 8,
    parameter int                    PORT_DEPTH = 8,
    parameter int                    PORT_WIDTH = 8,
    parameter logic [PORT_DEPTH-1:0] BASE_ADDR  = 8'hF0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic [PORT_DEPTH-1:0] port_id,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    input  logic [PORT_WIDTH-1:0] out_port,
    output logic [PORT_WIDTH-1:0] rd_data,
    output logic                  rd_hit,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    output logic [1:0]            state_dbg
);

    // Handshake: interrupt is held while in REQ; a one-cycle interrupt_ack in REQ
    // latches the winning source, and an EOI write in SERVICE releases it.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [PORT_DEPTH-1:0] A_PEND = BASE_ADDR;
    localparam logic [PORT_DEPTH-1:0] A_MASK = BASE_ADDR + PORT_DEPTH'(1);
    localparam logic [PORT_DEPTH-1:0] A_VEC  = BASE_ADDR + PORT_DEPTH'(2);

    state_t             r_state;
    state_t             w_next;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [2:0]         r_vec_idx;
    logic               r_active;
    logic               r_interrupt;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_masked;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_eoi_clr;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [2:0]         w_lowest;
    logic               w_latch;
    logic               w_sel_pend;
    logic               w_sel_mask;
    logic               w_sel_vec;
    logic               w_eoi;
    logic [PORT_WIDTH-1:0] w_rd;
    logic               w_unused_ok;

    assign w_sel_pend = (port_id == A_PEND);
    assign w_sel_mask = (port_id == A_MASK);
    assign w_sel_vec  = (port_id == A_VEC);

    assign w_edge   = irq_src & ~r_prev;
    assign w_masked = r_pending & r_mask;
    assign w_w1c    = (write_strobe && w_sel_pend) ? out_port[NUM_SRC-1:0] : '0;
    assign w_eoi    = write_strobe && w_sel_vec && (r_state == S_SERVICE);

    always_comb begin
        w_eoi_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_eoi && (r_vec_idx == i[2:0])) w_eoi_clr[i] = 1'b1;
        end
    end

    // New edges are OR'd in last so a same-cycle set beats any clear.
    assign w_pending_next = (r_pending & ~w_w1c & ~w_eoi_clr) | w_edge;

    always_comb begin
        w_lowest = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_masked[i]) w_lowest = i[2:0];
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_masked) w_next = S_REQ;
            end
            S_REQ: begin
                if (w_masked == '0) begin
                    w_next = S_IDLE;
                end else if (interrupt_ack) begin
                    w_next  = S_SERVICE;
                    w_latch = 1'b1;
                end
            end
            S_SERVICE: begin
                if (w_eoi) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_pending   <= '0;
            r_mask      <= '0;
            r_vec_idx   <= 3'd0;
            r_active    <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_prev      <= irq_src;
            r_pending   <= w_pending_next;
            r_interrupt <= (w_next == S_REQ);
            if (write_strobe && w_sel_mask) r_mask <= out_port[NUM_SRC-1:0];
            if (w_latch) begin
                r_vec_idx <= w_lowest;
                r_active  <= 1'b1;
            end else if (w_eoi) begin
                r_active  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_sel_pend) begin
            w_rd[NUM_SRC-1:0] = r_pending;
        end else if (w_sel_mask) begin
            w_rd[NUM_SRC-1:0] = r_mask;
        end else if (w_sel_vec) begin
            w_rd[7]   = r_active;
            w_rd[2:0] = r_vec_idx;
        end
    end

    assign rd_data     = w_rd;
    assign rd_hit      = w_sel_pend | w_sel_mask | w_sel_vec;
    assign interrupt   = r_interrupt;
    assign state_dbg   = r_state;
    // Reads are side-effect free, so the read strobe carries no information here.
    assign w_unused_ok = &{1'b0, read_strobe};

endmodule
